// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo-N counter sequencer.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   MIN_MOD   : smallest modulus accepted on start
//   DEF_CNT_W : default width of count / modulus
//   DEF_REP_W : default width of repetition count
package mod_counter_pkg;

   localparam int DEF_CNT_W = 3;
   localparam int DEF_REP_W = 4;
   localparam int MIN_MOD   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with registered terminal (wrap) pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   en    : advance the count this cycle
//   clr   : force count to 0 and suppress wrap (priority over en)
//   mod   : modulus N; count runs 0..N-1
//   count : current count
//   wrap  : one-cycle pulse in the cycle after count went N-1 -> 0
module mod_n_counter
   import mod_counter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] mod,
   output logic [CNT_W-1:0] count,
   output logic             wrap
);

   logic at_term;

   assign at_term = (count == (mod - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (en) begin
         if (at_term) begin
            count <= '0;
            wrap  <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
            wrap  <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_counter_sequencer.sv
// Runs a modulo-N counter for a requested number of full wraps, then pulses
// done. Modulus and repetition count are captured on an accepted start.
// Optional macro MOD_COUNTER_PAUSE_EN adds a pause input that freezes a run.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request pulse, honoured only in IDLE
//   mod_val : modulus N (must be >= 2, otherwise err pulses)
//   reps    : number of wraps; 0 = free-run until abort
//   abort   : end a run early (returns to IDLE, no done)
//   pause   : (MOD_COUNTER_PAUSE_EN only) hold count and wrap tally in RUN
//   busy    : high in RUN
//   count   : current count 0..N-1
//   wrap    : one-cycle pulse on each N-1 -> 0 rollover
//   done    : one-cycle pulse after the final wrap
//   err     : one-cycle pulse when start is rejected
//
// state | meaning
// IDLE  | waiting for start, counter held at 0
// RUN   | counting; wraps tallied down from reps
// DONE  | single-cycle completion, counter held at 0
module mod_counter_sequencer
   import mod_counter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] mod_val,
   input  logic [REP_W-1:0] reps,
   input  logic             abort,
`ifdef MOD_COUNTER_PAUSE_EN
   input  logic             pause,
`endif
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             done,
   output logic             err
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] mod_q;
   logic [REP_W-1:0] reps_q;
   logic [REP_W-1:0] wrap_left;
   logic             err_q;
   logic             mod_ok;
   logic             hold;
   logic             last_wrap;
   logic             cnt_en;
   logic             cnt_clr;

`ifdef MOD_COUNTER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign mod_ok = (mod_val >= CNT_W'(MIN_MOD));

   // wrap_left only reaches 0 with reps_q != 0 when the final wrap landed
   // while paused; the DONE transition is then taken once pause drops.
   assign last_wrap = (reps_q != '0) &&
                      ((wrap_left == '0) || (wrap && (wrap_left == REP_W'(1))));

   always_comb begin
      state_nxt = state;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (start && mod_ok) state_nxt = RUN;
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_clr   = 1'b1;
            end else if (last_wrap && !hold) begin
               state_nxt = DONE;
               cnt_clr   = 1'b1;
            end else begin
               cnt_en = !hold;
            end
         end
         DONE: begin
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mod_q     <= '0;
         reps_q    <= '0;
         wrap_left <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= (state == IDLE) && start && !mod_ok;
         if ((state == IDLE) && start && mod_ok) begin
            mod_q     <= mod_val;
            reps_q    <= reps;
            wrap_left <= reps;
         end else if ((state == RUN) && wrap && (wrap_left != '0)) begin
            wrap_left <= wrap_left - REP_W'(1);
         end
      end
   end

   mod_n_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .mod   (mod_q),
      .count (count),
      .wrap  (wrap)
   );

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign err  = err_q;

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Bench for mod_counter_sequencer: each scenario pushes its expected
// per-cycle {busy,count,wrap,done,err} into a queue, then drives stimulus
// and pops one expectation after every clock edge.
module tb_mod_counter_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] mod_val;
   logic [3:0] reps;
   logic       abort;
   logic       pause;
   logic       busy;
   logic [2:0] count;
   logic       wrap;
   logic       done;
   logic       err;

   logic [6:0] obs;
   logic [6:0] exp_v;
   logic [6:0] exp_q[$];
   int         checks;
   int         errors;

   mod_counter_sequencer #(
      .CNT_W (3),
      .REP_W (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mod_val (mod_val),
      .reps    (reps),
      .abort   (abort),
`ifdef MOD_COUNTER_PAUSE_EN
      .pause   (pause),
`endif
      .busy    (busy),
      .count   (count),
      .wrap    (wrap),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {busy, count, wrap, done, err};

   function automatic logic [6:0] ev(input logic b, input int c, input logic w,
                                     input logic d, input logic e);
      logic [2:0] c3;
      c3 = c[2:0];
      return {b, c3, w, d, e};
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 8; c++) begin
         if (c < 2 || c == 6)  exp_q.push_back(ev(0, 0, 0, 0, 0));
         else if (c == 3)      exp_q.push_back(ev(1, 0, 0, 0, 0));
         else if (c == 4)      exp_q.push_back(ev(1, 1, 0, 0, 0));
         else if (c == 5)      exp_q.push_back(ev(1, 2, 0, 0, 0));
         else                  exp_q.push_back(ev(0, 0, 0, 0, 0));
      end
      for (int c = 0; c < 8; c++) begin
         rst     = (c < 2 || c == 6);
         start   = (c < 2 || c == 3);
         mod_val = 3'd7;
         reps    = (c < 2) ? 4'd2 : 4'd0;
         abort   = 1'b0;
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_nominal();
      for (int c = 0; c < 17; c++) begin
         if (c <= 14)      exp_q.push_back(ev(1, c % 7, (c == 7 || c == 14), 0, 0));
         else if (c == 15) exp_q.push_back(ev(0, 0, 0, 1, 0));
         else              exp_q.push_back(ev(0, 0, 0, 0, 0));
      end
      for (int c = 0; c < 17; c++) begin
         start   = (c == 0);
         mod_val = 3'd7;
         reps    = 4'd2;
         abort   = 1'b0;
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL nominal cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reject();
      for (int c = 0; c < 4; c++)
         exp_q.push_back(ev(0, 0, 0, 0, (c == 0 || c == 2)));
      for (int c = 0; c < 4; c++) begin
         start   = (c == 0 || c == 2);
         mod_val = (c < 2) ? 3'd1 : 3'd0;
         reps    = 4'd3;
         abort   = 1'b0;
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reject cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_abort();
      // mod 5, reps 3; abort sampled while count==3 of the second pass
      for (int c = 0; c < 11; c++) begin
         if (c <= 8) exp_q.push_back(ev(1, c % 5, (c == 5), 0, 0));
         else        exp_q.push_back(ev(0, 0, 0, 0, 0));
      end
      for (int c = 0; c < 11; c++) begin
         start   = (c == 0);
         mod_val = 3'd5;
         reps    = 4'd3;
         abort   = (c == 9);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL abort cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      abort = 1'b0; start = 1'b0;
   endtask

   task automatic test_abort_final();
      // mod 3, reps 2; abort sampled on the edge of the final rollover
      for (int c = 0; c < 8; c++) begin
         if (c <= 5) exp_q.push_back(ev(1, c % 3, (c == 3), 0, 0));
         else        exp_q.push_back(ev(0, 0, 0, 0, 0));
      end
      for (int c = 0; c < 8; c++) begin
         start   = (c == 0);
         mod_val = 3'd3;
         reps    = 4'd2;
         abort   = (c == 6);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL abort_final cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      abort = 1'b0; start = 1'b0;
   endtask

   task automatic test_ignored();
      // run mod 5 reps 1; start with mod 4 mid-run and start in DONE ignored;
      // start in the following IDLE cycle accepted (mod 3 reps 1)
      for (int c = 0; c <= 4; c++) exp_q.push_back(ev(1, c, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 1, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 1, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 2, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 1, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 1, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0));
      for (int c = 0; c < 14; c++) begin
         start   = (c == 0 || c == 2 || c == 7 || c == 8);
         mod_val = (c < 2) ? 3'd5 : (c < 7) ? 3'd4 : 3'd3;
         reps    = 4'd1;
         abort   = 1'b0;
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL ignored cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_free_run();
      for (int c = 0; c < 62; c++) begin
         if (c < 60) exp_q.push_back(ev(1, c % 3, (c > 0 && c % 3 == 0), 0, 0));
         else        exp_q.push_back(ev(0, 0, 0, 0, 0));
      end
      for (int c = 0; c < 62; c++) begin
         start   = (c == 0);
         mod_val = 3'd3;
         reps    = 4'd0;
         abort   = (c == 60);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL free_run cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      abort = 1'b0; start = 1'b0;
   endtask

`ifdef MOD_COUNTER_PAUSE_EN
   task automatic test_pause();
      // mod 5 reps 1; pause for 4 cycles at count 1 delays the wrap by 4
      exp_q.push_back(ev(1, 0, 0, 0, 0));
      for (int c = 1; c <= 5; c++) exp_q.push_back(ev(1, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 2, 0, 0, 0));
      exp_q.push_back(ev(1, 3, 0, 0, 0));
      exp_q.push_back(ev(1, 4, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 1, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 1, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0));
      for (int c = 0; c < 12; c++) begin
         start   = (c == 0);
         mod_val = 3'd5;
         reps    = 4'd1;
         abort   = 1'b0;
         pause   = (c >= 2 && c <= 5);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL pause cyc %0d got %b want %b", c, obs, exp_v);
         end
      end
      pause = 1'b0; start = 1'b0;
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      start   = 1'b0;
      mod_val = '0;
      reps    = '0;
      abort   = 1'b0;
      pause   = 1'b0;
      test_reset();
      test_nominal();
      test_reject();
      test_abort();
      test_abort_final();
      test_ignored();
      test_free_run();
`ifdef MOD_COUNTER_PAUSE_EN
      test_pause();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
